c64_rom_banker: RTL

//  CPU-side memory banker feeding the BASIC, KERNAL and CHAR synchronous ROMs.

---
 rtl/c64_rom_banker_pkg.sv | 23 ++
 rtl/c64_rom_banker_if.sv | 16 +
 rtl/c64_rom_banker_cpu_port.sv | 41 ++++
 rtl/c64_rom_banker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/c64_rom_banker_pkg.sv
// c64_mem_pkg: shared types and constants for the C64 CPU-side ROM banker.
//   src_t      - data source latched at request accept
//   *_BASE/_LIMIT - CPU address regions
//   *_BIT      - bank-bit positions inside the effective port value
package c64_mem_pkg;

  typedef enum logic [2:0] {
    RAM, BASIC, KERNAL, CHAR, IO, PORT_DDR, PORT_DATA
  } src_t;

  localparam logic [15:0] PORT_DDR_ADDR  = 16'h0000;
  localparam logic [15:0] PORT_DATA_ADDR = 16'h0001;
  localparam logic [15:0] BASIC_BASE     = 16'hA000;
  localparam logic [15:0] BASIC_LIMIT    = 16'hBFFF;
  localparam logic [15:0] IO_BASE        = 16'hD000;
  localparam logic [15:0] IO_LIMIT       = 16'hDFFF;
  localparam logic [15:0] KERNAL_BASE    = 16'hE000;  // runs to $FFFF

  localparam int LORAM_BIT  = 0;
  localparam int HIRAM_BIT  = 1;
  localparam int CHAREN_BIT = 2;

endpackage

// File: rtl/c64_rom_banker_if.sv
// c64_rom_banker_if: CPU request/ack bus.
//   master - CPU side: drives addr/wdata/we/req, receives rdata/ack
//   slave  - banker side
interface c64_rom_banker_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_req;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  modport master (output cpu_addr, cpu_wdata, cpu_we, cpu_req,
                  input  cpu_rdata, cpu_ack);
  modport slave  (input  cpu_addr, cpu_wdata, cpu_we, cpu_req,
                  output cpu_rdata, cpu_ack);
endinterface

// File: rtl/c64_rom_banker_cpu_port.sv
// c64_cpu_port: 6510 on-chip I/O port ($00 DDR, $01 DATA).
//   wr_ddr_i/wr_data_i/wdata_i - register write controls
//   port_in_i  - external pin levels
//   ddr_o      - DDR register
//   port_rd_o  - value seen by a CPU read of $01
//   bank_o     - effective LORAM/HIRAM/CHAREN bits
//   port_out_o - pin drive (DATA where DDR=1, else 0)
module c64_cpu_port #(
  parameter logic [7:0] PORT_PULLUP = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ddr_i,
  input  logic       wr_data_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] port_in_i,
  output logic [7:0] ddr_o,
  output logic [7:0] port_rd_o,
  output logic [2:0] bank_o,
  output logic [7:0] port_out_o
);
  logic [7:0] ddr_q, data_q, eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr_q  <= 8'h00;
      data_q <= 8'h00;
    end else begin
      if (wr_ddr_i)  ddr_q  <= wdata_i;
      if (wr_data_i) data_q <= wdata_i;
    end
  end

  // Bank lines follow the pins on input bits, the DATA register on output bits.
  assign eff        = (ddr_q & data_q) | (~ddr_q & port_in_i);
  assign bank_o     = eff[2:0];
  // Undriven/absent input bits read back through the pull-up mask.
  assign port_rd_o  = (ddr_q & data_q) | (~ddr_q & port_in_i & PORT_PULLUP);
  assign port_out_o = ddr_q & data_q;
  assign ddr_o      = ddr_q;
endmodule

// File: rtl/c64_rom_banker.sv
// c64_rom_banker: CPU-side banker for BASIC/KERNAL/CHAR synchronous ROMs.
//   clk, reset      - clock, async active-high reset
//   cpu             - req/ack bus (slave side)
//   port_in/out     - 6510 port pins
//   *_addr          - registered ROM addresses
//   *_data          - ROM/RAM/IO read data, ROM_LATENCY clocks after address
//   ram_we, io_we   - one-clock write strobes
module c64_rom_banker
  import c64_mem_pkg::*;
#(
  parameter int         ROM_LATENCY = 1,
  parameter logic [7:0] PORT_PULLUP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  c64_rom_banker_if.slave   cpu,
  input  logic [7:0]        port_in,
  output logic [7:0]        port_out,
  output logic [12:0]       basic_addr,
  output logic [12:0]       kernal_addr,
  output logic [11:0]       char_addr,
  input  logic [7:0]        basic_data,
  input  logic [7:0]        kernal_data,
  input  logic [7:0]        char_data,
  input  logic [7:0]        ram_data,
  input  logic [7:0]        io_data,
  output logic              ram_we,
  output logic              io_we
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] LAT    = 2'(ROM_LATENCY);

  logic [1:0]  state_q, state_d, cnt_q, cnt_d;
  src_t        src_q, src_d, src_dec;
  logic [7:0]  rdata_q, rdata_d;
  logic        ram_we_q, ram_we_d, io_we_q, io_we_d;
  logic [12:0] basic_q, basic_d, kernal_q, kernal_d;
  logic [11:0] char_q, char_d;
  logic [7:0]  ddr, port_rd;
  logic [2:0]  bank;
  logic        accept, lo, hi, ch;

  assign accept = (state_q == S_IDLE) && cpu.cpu_req;

  c64_cpu_port #(.PORT_PULLUP(PORT_PULLUP)) u_port (
    .clk        (clk),
    .reset      (reset),
    .wr_ddr_i   (accept && cpu.cpu_we && src_dec == PORT_DDR),
    .wr_data_i  (accept && cpu.cpu_we && src_dec == PORT_DATA),
    .wdata_i    (cpu.cpu_wdata),
    .port_in_i  (port_in),
    .ddr_o      (ddr),
    .port_rd_o  (port_rd),
    .bank_o     (bank),
    .port_out_o (port_out)
  );

  assign lo = bank[LORAM_BIT];
  assign hi = bank[HIRAM_BIT];
  assign ch = bank[CHAREN_BIT];

  always_comb begin
    src_dec = RAM;
    if (cpu.cpu_addr == PORT_DDR_ADDR)       src_dec = PORT_DDR;
    else if (cpu.cpu_addr == PORT_DATA_ADDR) src_dec = PORT_DATA;
    else if (cpu.cpu_addr >= BASIC_BASE && cpu.cpu_addr <= BASIC_LIMIT) begin
      if (lo && hi) src_dec = BASIC;
    end else if (cpu.cpu_addr >= KERNAL_BASE) begin
      if (hi) src_dec = KERNAL;
    end else if (cpu.cpu_addr >= IO_BASE && cpu.cpu_addr <= IO_LIMIT) begin
      if (lo || hi) src_dec = ch ? IO : CHAR;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    rdata_d  = rdata_q;
    ram_we_d = 1'b0;
    io_we_d  = 1'b0;
    basic_d  = basic_q;
    kernal_d = kernal_q;
    char_d   = char_q;
    case (state_q)
      S_IDLE: if (cpu.cpu_req) begin
        src_d    = src_dec;
        basic_d  = cpu.cpu_addr[12:0];
        kernal_d = cpu.cpu_addr[12:0];
        char_d   = cpu.cpu_addr[11:0];
        if (cpu.cpu_we) begin
          // ROM-mapped writes fall through to the RAM underneath.
          state_d = S_ACK;
          if (src_dec == IO) io_we_d = 1'b1;
          else if (src_dec != PORT_DDR && src_dec != PORT_DATA) ram_we_d = 1'b1;
        end else if (src_dec == PORT_DDR || src_dec == PORT_DATA) begin
          state_d = S_ACK;
          rdata_d = (src_dec == PORT_DDR) ? ddr : port_rd;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT;
        end
      end
      // One extra WAIT clock beyond the count covers the address register stage.
      S_WAIT: if (cnt_q == 2'd0) begin
        state_d = S_ACK;
        case (src_q)
          BASIC:   rdata_d = basic_data;
          KERNAL:  rdata_d = kernal_data;
          CHAR:    rdata_d = char_data;
          IO:      rdata_d = io_data;
          default: rdata_d = ram_data;
        endcase
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      src_q    <= RAM;
      rdata_q  <= 8'h00;
      ram_we_q <= 1'b0;
      io_we_q  <= 1'b0;
      basic_q  <= 13'h0;
      kernal_q <= 13'h0;
      char_q   <= 12'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      rdata_q  <= rdata_d;
      ram_we_q <= ram_we_d;
      io_we_q  <= io_we_d;
      basic_q  <= basic_d;
      kernal_q <= kernal_d;
      char_q   <= char_d;
    end
  end

  assign cpu.cpu_ack   = (state_q == S_ACK);
  assign cpu.cpu_rdata = rdata_q;
  assign ram_we        = ram_we_q;
  assign io_we         = io_we_q;
  assign basic_addr    = basic_q;
  assign kernal_addr   = kernal_q;
  assign char_addr     = char_q;
endmodule
